// File: rtl/karatsuba_34x43_arbiter.sv
// Round-robin front end sharing one pipelined 34x43 Karatsuba multiplier among NREQ requesters.
// Results return in issue order through a credit-protected show-ahead FIFO.

module karatsuba_pipe_reg #(
   parameter int W  = 1,
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   generate
      if (EN) begin : g_reg
         logic [W-1:0] q_q;
         always_ff @(posedge clk) begin
            if (rst) q_q <= '0;
            else     q_q <= d_i;
         end
         assign q_o = q_q;
      end else begin : g_wire
         assign q_o = d_i;
      end
   endgenerate
endmodule

module karatsuba_34x43_rtl #(
   parameter bit S1 = 1'b1,
   parameter bit S2 = 1'b1,
   parameter bit S3 = 1'b1,
   parameter bit S4 = 1'b1,
   parameter bit S5 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [33:0] a_i,
   input  logic [42:0] b_i,
   output logic [76:0] p_o
);
   // A = a1*2^17 + a0, B = b1*2^17 + b0; three multiplies instead of four.
   logic [76:0]  s1;
   logic [121:0] s2_d, s2, s3_d, s3, s4_d, s4;
   logic [16:0]  a1, a0, b0;
   logic [25:0]  b1;
   logic [17:0]  sa;
   logic [26:0]  sb;
   logic [42:0]  z2_3, z2_4;
   logic [33:0]  z0_3, z0_4;
   logic [44:0]  zm_3, z1_4;
   logic [76:0]  p_d;

   karatsuba_pipe_reg #(.W(77),  .EN(S1)) u_s1 (.clk(clk), .rst(rst), .d_i({a_i, b_i}), .q_o(s1));

   assign a1   = s1[76:60];
   assign a0   = s1[59:43];
   assign b1   = s1[42:17];
   assign b0   = s1[16:0];
   assign sa   = {1'b0, a1} + {1'b0, a0};
   assign sb   = {1'b0, b1} + {10'b0, b0};
   assign s2_d = {a1, a0, b1, b0, sa, sb};
   karatsuba_pipe_reg #(.W(122), .EN(S2)) u_s2 (.clk(clk), .rst(rst), .d_i(s2_d), .q_o(s2));

   assign z2_3 = {26'b0, s2[121:105]} * {17'b0, s2[87:62]};
   assign z0_3 = {17'b0, s2[104:88]} * {17'b0, s2[61:45]};
   assign zm_3 = {27'b0, s2[44:27]} * {18'b0, s2[26:0]};
   assign s3_d = {z2_3, z0_3, zm_3};
   karatsuba_pipe_reg #(.W(122), .EN(S3)) u_s3 (.clk(clk), .rst(rst), .d_i(s3_d), .q_o(s3));

   assign z1_4 = s3[44:0] - {2'b0, s3[121:79]} - {11'b0, s3[78:45]};
   assign s4_d = {s3[121:79], s3[78:45], z1_4};
   karatsuba_pipe_reg #(.W(122), .EN(S4)) u_s4 (.clk(clk), .rst(rst), .d_i(s4_d), .q_o(s4));

   assign z2_4 = s4[121:79];
   assign z0_4 = s4[78:45];
   assign p_d  = {z2_4, 34'b0} + {15'b0, s4[44:0], 17'b0} + {43'b0, z0_4};
   karatsuba_pipe_reg #(.W(77),  .EN(S5)) u_s5 (.clk(clk), .rst(rst), .d_i(p_d), .q_o(p_o));
endmodule

module karatsuba_34x43_arbiter #(
   parameter int NREQ       = 4,
   parameter int MUL_LAT    = 5,
   parameter int FIFO_DEPTH = 8,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*34-1:0] req_a,
   input  logic [NREQ*43-1:0] req_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [76:0]        res_c,
   output logic [IDW-1:0]     res_id,
   output logic               busy
);
   localparam int OCCW = $clog2(FIFO_DEPTH + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int EW   = IDW + 77;

   logic [IDW-1:0]  ptr_q, ptr_d, grant;
   logic [OCCW-1:0] occ_q, occ_d;
   logic [IDW:0]    scan;
   logic            issue, pop, wr_en, fifo_nonempty;
   logic [33:0]     a_arr [NREQ];
   logic [42:0]     b_arr [NREQ];
   logic [33:0]     mul_a;
   logic [42:0]     mul_b;
   logic [76:0]     mul_p;
   logic [MUL_LAT-1:0] sh_vld_q;
   logic [IDW-1:0]  sh_id_q [MUL_LAT];
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [EW-1:0]   head;
   logic [AW:0]     wr_q, rd_q;

   // Scan downwards so the nearest valid requester after ptr is the last one written.
   always_comb begin
      grant = '0;
      scan  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan = {1'b0, ptr_q} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
         if (req_valid[scan[IDW-1:0]]) grant = scan[IDW-1:0];
      end
   end

   // Credit comes only from the registered count, so a same-cycle pop cannot be spent.
   assign issue = !rst && (|req_valid) && (occ_q < OCCW'(FIFO_DEPTH));
   assign pop   = res_valid && res_ready;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_ready[gi] = issue && (grant == IDW'(gi));
         assign a_arr[gi]     = req_a[34*gi +: 34];
         assign b_arr[gi]     = req_b[43*gi +: 43];
      end
   endgenerate

   assign mul_a = a_arr[grant];
   assign mul_b = b_arr[grant];

   karatsuba_34x43_rtl #(.S1(1'b1), .S2(1'b1), .S3(1'b1), .S4(1'b1), .S5(1'b1)) u_mul (
      .clk(clk), .rst(rst), .a_i(mul_a), .b_i(mul_b), .p_o(mul_p)
   );

   always_comb begin
      ptr_d = ptr_q;
      occ_d = occ_q;
      if (issue) ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      if (issue && !pop)      occ_d = occ_q + OCCW'(1);
      else if (!issue && pop) occ_d = occ_q - OCCW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         occ_q    <= '0;
         sh_vld_q <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
      end else begin
         ptr_q    <= ptr_d;
         occ_q    <= occ_d;
         sh_vld_q <= {sh_vld_q[MUL_LAT-2:0], issue};
         if (wr_en) wr_q <= wr_q + (AW+1)'(1);
         if (pop)   rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      sh_id_q[0] <= grant;
      for (int k = 1; k < MUL_LAT; k++) sh_id_q[k] <= sh_id_q[k-1];
   end

   assign wr_en = sh_vld_q[MUL_LAT-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= {sh_id_q[MUL_LAT-1], mul_p};
   end

   assign head          = mem_q[rd_q[AW-1:0]];
   assign fifo_nonempty = (wr_q != rd_q);
   assign res_valid     = !rst && fifo_nonempty;
   assign res_c         = res_valid ? head[76:0] : '0;
   assign res_id        = res_valid ? head[EW-1:77] : '0;
   assign busy          = !rst && (occ_q != '0);
endmodule
